// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Main control unit of a multicycle MIPS processor. A Moore FSM steps through
// FETCH / DECODE and an opcode-dependent execution path, and drives every
// datapath control line from the current state alone.
//
// The control lines are held in a register. It is loaded with the decode of
// the *next* state, so it always equals decode(state). The outputs therefore
// stay a pure function of the state register and come glitch-free from flops.
//
// Optional feature (macro CONTROL_ADDI_EN):
//   When defined, opcode 001000 (addi) runs DECODE -> ADDIEX -> ADDIWB -> FETCH.
//   When undefined, addi is treated as an illegal opcode (DECODE -> FETCH).
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (forces FETCH)
//   opcode[5:0]  in   instruction[31:26] from IR; sampled in DECODE and MEMADR
//   PCWriteCond  out  conditional PC write (branch)
//   PCWrite      out  unconditional PC write
//   IorD         out  memory address select: 0=PC, 1=ALUOut
//   MemRead      out  memory read enable
//   MemWrite     out  memory write enable
//   MemtoReg     out  register write data: 0=ALUOut, 1=MDR
//   IRWrite      out  instruction register load
//   RegDst       out  write register: 0=rt, 1=rd
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A: 0=PC, 1=A reg
//   ALUSrcB[1:0] out  ALU B: 00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   ALUOp[1:0]   out  00=add, 01=sub, 10=funct-decoded
//   PCSource[1:0] out 00=ALU result, 01=ALUOut, 10=jump target
//   state[3:0]   out  current state (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  // State encodings (fixed; visible on the debug port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef CONTROL_ADDI_EN
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
`endif

  // Opcodes recognised by the sequencer
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // Full set of datapath control lines, kept together so one register holds them
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Control-line decode of one state; anything not set stays 0, including
  // the unused encodings.
  function automatic ctrl_t decode_ctrl(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
`ifdef CONTROL_ADDI_EN
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
`endif
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  ctrl_t      ctrl_r;

  // Next-state selection; opcode only matters in DECODE and MEMADR
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW:    next_state_s = S_MEMADR;
          OP_SW:    next_state_s = S_MEMADR;
          OP_RTYPE: next_state_s = S_EXEC;
          OP_BEQ:   next_state_s = S_BRANCH;
          OP_J:     next_state_s = S_JUMP;
`ifdef CONTROL_ADDI_EN
          OP_ADDI:  next_state_s = S_ADDIEX;
`endif
          // Illegal opcode: skip the instruction without side effects
          default:  next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:  next_state_s = S_MEMWB;
      S_MEMWB:  next_state_s = S_FETCH;
      S_MEMWR:  next_state_s = S_FETCH;
      S_EXEC:   next_state_s = S_RWB;
      S_RWB:    next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
`ifdef CONTROL_ADDI_EN
      S_ADDIEX: next_state_s = S_ADDIWB;
      S_ADDIWB: next_state_s = S_FETCH;
`endif
      default:  next_state_s = S_FETCH;
    endcase
  end

  // State register; reset drops straight into FETCH regardless of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Control register loaded with the decode of the state being entered, so
  // it tracks decode(state_r) exactly, including during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= decode_ctrl(S_FETCH);
    end else begin
      ctrl_r <= decode_ctrl(next_state_s);
    end
  end

  assign state       = state_r;
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign PCWrite     = ctrl_r.pc_write;
  assign IorD        = ctrl_r.i_or_d;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign IRWrite     = ctrl_r.ir_write;
  assign RegDst      = ctrl_r.reg_dst;
  assign RegWrite    = ctrl_r.reg_write;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign ALUOp       = ctrl_r.alu_op;
  assign PCSource    = ctrl_r.pc_source;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Runs a directed set of instructions followed by random opcodes through the
// control FSM. The expected state path of each instruction comes from its
// instruction class, and the expected control lines come from a per-state
// table. Opcode is randomised in every state where it must be ignored.
// Resets are asserted asynchronously in the middle of instructions.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int path[$];

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected control lines for one state, packed in port order:
  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] exp_ctrl(input int st);
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca;
    logic [1:0] srcb, aop, psrc;
    {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca} = 10'b0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; irw = 1'b1; srcb = 2'b01; pcw = 1'b1; end
      1:  begin srcb = 2'b11; end
      2:  begin srca = 1'b1; srcb = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin srca = 1'b1; aop = 2'b10; end
      7:  begin rdst = 1'b1; rw = 1'b1; end
      8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      9:  begin pcw = 1'b1; psrc = 2'b10; end
      10: begin srca = 1'b1; srcb = 2'b10; end
      11: begin rw = 1'b1; end
      default: begin end
    endcase
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, aop, psrc};
  endfunction

  // Visited states for one instruction, from its class (length = CPI)
  function automatic void build_path(input logic [5:0] op);
    path = {0, 1};
    case (op)
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b000100: path.push_back(8);
      6'b000010: path.push_back(9);
`ifdef CONTROL_ADDI_EN
      6'b001000: begin path.push_back(10); path.push_back(11); end
`endif
      default: begin end
    endcase
  endfunction

  task automatic check_cycle(input string tag, input int st);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " ctrl"},
          32'({PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}),
          32'(exp_ctrl(st)));
  endtask

  // Runs one instruction starting at a negedge in FETCH; if abort_at hits a
  // path index, reset is pulsed mid-cycle there and the task ends in FETCH.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    build_path(op);
    for (int k = 0; k < path.size(); k++) begin
      check_cycle($sformatf("op%02h step%0d", op, k), path[k]);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_cycle("async reset", 0);
        @(posedge clk);
        #1;
        check_cycle("held reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (path[k] == 1 || path[k] == 2) begin
        opcode = op;
      end else begin
        opcode = 6'($urandom);
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  logic [5:0] directed  [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'b001000};

  initial begin
    // Reset asserted asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #1 check_cycle("initial reset", 0);
    @(negedge clk);
    check_cycle("reset over edge", 0);
    rst_n = 1'b1;

    foreach (directed[i]) run_instr(directed[i], -1);

    // lw aborted in MEMRD
    run_instr(6'b100011, 3);
    run_instr(6'b000000, -1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int ab;
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 5)];
      else op = 6'($urandom);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
